id_stage: RTL and testbench



---
 rtl/id_stage_pkg.sv | 64 ++++++
 rtl/id_stage_if.sv | 50 +++++
 rtl/id_scoreboard.sv | 43 ++++
 rtl/id_stage.sv | 169 ++++++++++++++++
 tb/tb_id_stage.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pkg.sv
// +--------------------------------------------------------------------+
// | id_stage_pkg : RV32I opcode/funct3 constants and format classifier |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

package id_stage_pkg;

  localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] INST_TYPE_L   = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S   = 7'b0100011;
  localparam logic [6:0] INST_TYPE_B   = 7'b1100011;
  localparam logic [6:0] INST_JAL      = 7'b1101111;
  localparam logic [6:0] INST_JALR     = 7'b1100111;
  localparam logic [6:0] INST_LUI      = 7'b0110111;
  localparam logic [6:0] INST_AUIPC    = 7'b0010111;
  localparam logic [6:0] INST_FENCE    = 7'b0001111;
  localparam logic [6:0] INST_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;

  typedef enum logic [3:0] {
    FMT_R     = 4'd0,
    FMT_I     = 4'd1,
    FMT_S     = 4'd2,
    FMT_B     = 4'd3,
    FMT_U     = 4'd4,
    FMT_J     = 4'd5,
    FMT_FENCE = 4'd6,
    FMT_SYS   = 4'd7,
    FMT_ILL   = 4'd8
  } fmt_e;

  function automatic fmt_e fmt_of(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      INST_TYPE_R_M:                       f = FMT_R;
      INST_TYPE_I, INST_TYPE_L, INST_JALR: f = FMT_I;
      INST_TYPE_S:                         f = FMT_S;
      INST_TYPE_B:                         f = FMT_B;
      INST_LUI, INST_AUIPC:                f = FMT_U;
      INST_JAL:                            f = FMT_J;
      INST_FENCE:                          f = FMT_FENCE;
      INST_SYSTEM:                         f = FMT_SYS;
      default:                             f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_if.sv
// +--------------------------------------------------------------------+
// | id_stage_if : fetch-side, register-file, writeback and issue bus   |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

interface id_stage_if #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          inst_i;
  logic [XLEN-1:0]      inst_addr_i;
  logic [RF_ADDR_W-1:0] rs1_addr_o;
  logic [RF_ADDR_W-1:0] rs2_addr_o;
  logic [XLEN-1:0]      rs1_data_i;
  logic [XLEN-1:0]      rs2_data_i;
  logic                 wb_valid;
  logic [RF_ADDR_W-1:0] wb_rd;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      op1_o;
  logic [XLEN-1:0]      op2_o;
  logic [XLEN-1:0]      imm_o;
  logic [31:0]          inst_o;
  logic [XLEN-1:0]      inst_addr_o;
  logic [RF_ADDR_W-1:0] rd_addr_o;
  logic                 reg_wen;
  logic                 illegal_o;

  // Surrounding pipeline / environment side
  modport master (
    output in_valid, inst_i, inst_addr_i, rs1_data_i, rs2_data_i,
           wb_valid, wb_rd, flush, out_ready,
    input  in_ready, rs1_addr_o, rs2_addr_o, out_valid, op1_o, op2_o,
           imm_o, inst_o, inst_addr_o, rd_addr_o, reg_wen, illegal_o
  );

  // Decode stage side
  modport slave (
    input  in_valid, inst_i, inst_addr_i, rs1_data_i, rs2_data_i,
           wb_valid, wb_rd, flush, out_ready,
    output in_ready, rs1_addr_o, rs2_addr_o, out_valid, op1_o, op2_o,
           imm_o, inst_o, inst_addr_o, rd_addr_o, reg_wen, illegal_o
  );
endinterface

`default_nettype wire

// File: rtl/id_scoreboard.sv
// +--------------------------------------------------------------------+
// | id_scoreboard : pending-write bitmap, set beats clear, x0 ignored  |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

module id_scoreboard #(
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [RF_ADDR_W-1:0] set_addr,
  input  logic                 clr_en,
  input  logic [RF_ADDR_W-1:0] clr_addr,
  input  logic [RF_ADDR_W-1:0] rd1_addr,
  output logic                 rd1_busy,
  input  logic [RF_ADDR_W-1:0] rd2_addr,
  output logic                 rd2_busy
);
  localparam int DEPTH = 2 ** RF_ADDR_W;

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Clear applied first so a same-register set overrides it
  always_comb begin
    pend_d = pend_q;
    if (clr_en && (clr_addr != '0)) pend_d[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) pend_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign rd1_busy = pend_q[rd1_addr];
  assign rd2_busy = pend_q[rd2_addr];

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// +--------------------------------------------------------------------+
// | id_stage : RV32I decode, RAW hazard stall and registered issue     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  bus
);
  logic [6:0]           opcode;
  fmt_e                 fmt;
  logic                 use_rs1;
  logic                 use_rs2;
  logic                 writes_rd;
  logic [31:0]          imm32;
  logic [RF_ADDR_W-1:0] rs1_addr;
  logic [RF_ADDR_W-1:0] rs2_addr;
  logic [RF_ADDR_W-1:0] rd_dec;
  logic                 wen_dec;
  logic                 busy1;
  logic                 busy2;
  logic                 hazard;
  logic                 in_ready;
  logic                 accept;
  logic                 issue;

  logic                 out_valid_q, out_valid_d;
  logic [XLEN-1:0]      op1_q, op1_d;
  logic [XLEN-1:0]      op2_q, op2_d;
  logic [XLEN-1:0]      imm_q, imm_d;
  logic [31:0]          inst_q, inst_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic [RF_ADDR_W-1:0] rd_q, rd_d;
  logic                 wen_q, wen_d;
  logic                 ill_q, ill_d;

  always_comb begin
    opcode    = bus.inst_i[6:0];
    fmt       = fmt_of(opcode);
    use_rs1   = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    use_rs2   = fmt inside {FMT_R, FMT_S, FMT_B};
    writes_rd = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
    // FENCE and SYSTEM share the I-type immediate field layout
    case (fmt)
      FMT_I, FMT_FENCE, FMT_SYS:
        imm32 = {{20{bus.inst_i[31]}}, bus.inst_i[31:20]};
      FMT_S:
        imm32 = {{20{bus.inst_i[31]}}, bus.inst_i[31:25], bus.inst_i[11:7]};
      FMT_B:
        imm32 = {{19{bus.inst_i[31]}}, bus.inst_i[31], bus.inst_i[7],
                 bus.inst_i[30:25], bus.inst_i[11:8], 1'b0};
      FMT_U:
        imm32 = {bus.inst_i[31:12], 12'b0};
      FMT_J:
        imm32 = {{11{bus.inst_i[31]}}, bus.inst_i[31], bus.inst_i[19:12],
                 bus.inst_i[20], bus.inst_i[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  always_comb begin
    rs1_addr = (bus.in_valid && use_rs1) ? RF_ADDR_W'(bus.inst_i[19:15]) : '0;
    rs2_addr = (bus.in_valid && use_rs2) ? RF_ADDR_W'(bus.inst_i[24:20]) : '0;
    rd_dec   = writes_rd ? RF_ADDR_W'(bus.inst_i[11:7]) : '0;
    wen_dec  = writes_rd && (rd_dec != '0);
  end

  id_scoreboard #(
    .RF_ADDR_W (RF_ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue && wen_q),
    .set_addr (rd_q),
    .clr_en   (bus.wb_valid),
    .clr_addr (bus.wb_rd),
    .rd1_addr (rs1_addr),
    .rd1_busy (busy1),
    .rd2_addr (rs2_addr),
    .rd2_busy (busy2)
  );

  // Unused or x0 sources carry address 0 and therefore never block
  always_comb begin
    hazard = 1'b0;
    if ((rs1_addr != '0) &&
        (busy1 || (out_valid_q && wen_q && (rd_q == rs1_addr))))
      hazard = 1'b1;
    if ((rs2_addr != '0) &&
        (busy2 || (out_valid_q && wen_q && (rd_q == rs2_addr))))
      hazard = 1'b1;
    in_ready = !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
    accept   = bus.in_valid && in_ready;
    issue    = out_valid_q && bus.out_ready;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    imm_d       = imm_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    wen_d       = wen_q;
    ill_d       = ill_q;
    if (accept) begin
      out_valid_d = 1'b1;
      op1_d       = use_rs1 ? bus.rs1_data_i : '0;
      op2_d       = use_rs2 ? bus.rs2_data_i : '0;
      imm_d       = XLEN'($signed(imm32));
      inst_d      = bus.inst_i;
      pc_d        = bus.inst_addr_i;
      rd_d        = wen_dec ? rd_dec : '0;
      wen_d       = wen_dec;
      ill_d       = (fmt == FMT_ILL);
    end else if (issue || bus.flush) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      imm_q       <= '0;
      inst_q      <= '0;
      pc_q        <= '0;
      rd_q        <= '0;
      wen_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      imm_q       <= imm_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      wen_q       <= wen_d;
      ill_q       <= ill_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.rs1_addr_o  = rs1_addr;
  assign bus.rs2_addr_o  = rs2_addr;
  assign bus.out_valid   = out_valid_q;
  assign bus.op1_o       = op1_q;
  assign bus.op2_o       = op2_q;
  assign bus.imm_o       = imm_q;
  assign bus.inst_o      = inst_q;
  assign bus.inst_addr_o = pc_q;
  assign bus.rd_addr_o   = rd_q;
  assign bus.reg_wen     = wen_q;
  assign bus.illegal_o   = ill_q;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// +--------------------------------------------------------------------+
// | tb_id_stage : directed stimulus with queued expected issue packets |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_id_stage;
  logic clk;
  logic rst;

  id_stage_if #(.XLEN(32), .RF_ADDR_W(5)) bus ();

  id_stage #(.XLEN(32), .RF_ADDR_W(5)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_act;
  exp_t        m_exp;
  logic [31:0] rf [32];
  int          checks;
  int          failures;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural register file read ports
  always_comb begin
    bus.rs1_data_i = rf[bus.rs1_addr_o];
    bus.rs2_data_i = rf[bus.rs2_addr_o];
  end

  function automatic exp_t mk(input logic [31:0] op1, input logic [31:0] op2,
                              input logic [31:0] imm, input logic [31:0] inst,
                              input logic [31:0] pc, input logic [4:0] rd,
                              input logic wen, input logic ill);
    exp_t e;
    e.op1 = op1; e.op2 = op2; e.imm = imm; e.inst = inst;
    e.pc = pc; e.rd = rd; e.wen = wen; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction; wait up to budget cycles for acceptance
  task automatic send(input string name, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [4:0] rs1a, input logic [4:0] rs2a,
                      input exp_t e, input int budget);
    int n;
    n = 0;
    bus.inst_i      = inst;
    bus.inst_addr_i = pc;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < budget) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_accept"}, 32'(bus.in_ready), 32'd1);
    chk({name, "_rs1_addr"}, 32'(bus.rs1_addr_o), 32'(rs1a));
    chk({name, "_rs2_addr"}, 32'(bus.rs2_addr_o), 32'(rs2a));
    if (bus.in_ready) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] val);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    rf[rd]       = val;
    step();
    bus.wb_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      m_act = mk(bus.op1_o, bus.op2_o, bus.imm_o, bus.inst_o, bus.inst_addr_o,
                 bus.rd_addr_o, bus.reg_wen, bus.illegal_o);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL issue_unexpected actual inst=%h required none", m_act.inst);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_act !== m_exp) begin
          failures++;
          $display("FAIL issue_payload actual op1=%h op2=%h imm=%h inst=%h pc=%h rd=%0d wen=%b ill=%b required op1=%h op2=%h imm=%h inst=%h pc=%h rd=%0d wen=%b ill=%b",
                   m_act.op1, m_act.op2, m_act.imm, m_act.inst, m_act.pc, m_act.rd, m_act.wen, m_act.ill,
                   m_exp.op1, m_exp.op2, m_exp.imm, m_exp.inst, m_exp.pc, m_exp.rd, m_exp.wen, m_exp.ill);
        end
      end
    end
  end

  initial begin
    checks          = 0;
    failures        = 0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[3]           = 32'h0000_0033;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.inst_i      = '0;
    bus.inst_addr_i = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_rd       = '0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_imm", bus.imm_o, 32'd0);
    chk("rst_inst", bus.inst_o, 32'd0);
    chk("rst_op1", bus.op1_o, 32'd0);
    chk("rst_wen_rd", {26'd0, bus.reg_wen, bus.rd_addr_o}, 32'd0);
    chk("rst_illegal", 32'(bus.illegal_o), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_sb", u_dut.u_sb.pend_q, 32'd0);
    step();

    // addi x1,x0,5 then dependent add x2,x1,x1
    bus.out_ready = 1'b1;
    send("addi_x1", 32'h0050_0093, 32'h100, 5'd0, 5'd0,
         mk(32'd0, 32'd0, 32'd5, 32'h0050_0093, 32'h100, 5'd1, 1'b1, 1'b0), 0);
    bus.inst_i      = 32'h0010_8133;
    bus.inst_addr_i = 32'h104;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    chk("raw_stall_issue_reg", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("raw_stall_sb", 32'(bus.in_ready), 32'd0);
    end
    step();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    rf[1]        = 32'd5;
    @(negedge clk);
    chk("raw_wb_same_cycle", 32'(bus.in_ready), 32'd0);
    step();
    bus.wb_valid = 1'b0;
    send("add_x2", 32'h0010_8133, 32'h104, 5'd1, 5'd1,
         mk(32'd5, 32'd5, 32'd0, 32'h0010_8133, 32'h104, 5'd2, 1'b1, 1'b0), 0);
    step();
    wb(5'd2, 32'd10);

    // sw x3,-4(x2)
    send("sw", 32'hFE31_2E23, 32'h108, 5'd2, 5'd3,
         mk(32'd10, 32'h33, 32'hFFFF_FFFC, 32'hFE31_2E23, 32'h108, 5'd0, 1'b0, 1'b0), 0);
    step();
    @(negedge clk);
    chk("sw_no_sb_set", u_dut.u_sb.pend_q, 32'd0);
    step();

    // lui x5 held under back-pressure
    bus.out_ready = 1'b0;
    send("lui_x5", 32'h1234_52B7, 32'h10C, 5'd0, 5'd0,
         mk(32'd0, 32'd0, 32'h1234_5000, 32'h1234_52B7, 32'h10C, 5'd5, 1'b1, 1'b0), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_imm", bus.imm_o, 32'h1234_5000);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("lui_sb5_set", 32'(u_dut.u_sb.pend_q[5]), 32'd1);
    step();

    // addi x4 issuing in the same cycle as a writeback of x4
    send("addi_x4", 32'h0070_0213, 32'h110, 5'd0, 5'd0,
         mk(32'd0, 32'd0, 32'd7, 32'h0070_0213, 32'h110, 5'd4, 1'b1, 1'b0), 0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd4;
    step();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("set_wins_sb4", 32'(u_dut.u_sb.pend_q[4]), 32'd1);
    chk("sb5_still_set", 32'(u_dut.u_sb.pend_q[5]), 32'd1);
    step();

    // back-to-back independent instructions, one per cycle
    send("beq", 32'h0001_8863, 32'h114, 5'd3, 5'd0,
         mk(32'h33, 32'd0, 32'd16, 32'h0001_8863, 32'h114, 5'd0, 1'b0, 1'b0), 0);
    send("addi_x6", 32'hFFF0_0313, 32'h118, 5'd0, 5'd0,
         mk(32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFF0_0313, 32'h118, 5'd6, 1'b1, 1'b0), 0);
    send("auipc_x7", 32'h0000_1397, 32'h200, 5'd0, 5'd0,
         mk(32'd0, 32'd0, 32'h0000_1000, 32'h0000_1397, 32'h200, 5'd7, 1'b1, 1'b0), 0);
    step();

    // flush kills jal x1 in the issue register
    bus.out_ready = 1'b0;
    send("jal_x1", 32'h0080_00EF, 32'h204, 5'd0, 5'd0,
         mk(32'd0, 32'd0, 32'd8, 32'h0080_00EF, 32'h204, 5'd1, 1'b1, 1'b0), 0);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("jal_out_valid", 32'(bus.out_valid), 32'd1);
    chk("jal_imm", bus.imm_o, 32'd8);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    step();
    bus.out_ready   = 1'b1;
    bus.inst_i      = 32'h1234_507F;
    bus.inst_addr_i = 32'h208;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_no_sb1", 32'(u_dut.u_sb.pend_q[1]), 32'd0);
    chk("flush_blocks_accept", 32'(bus.in_ready), 32'd0);
    step();
    bus.flush = 1'b0;

    // illegal opcode 0x7F
    send("illegal", 32'h1234_507F, 32'h208, 5'd0, 5'd0,
         mk(32'd0, 32'd0, 32'd0, 32'h1234_507F, 32'h208, 5'd0, 1'b0, 1'b1), 0);
    step();

    // reset with an entry held and registers pending
    bus.out_ready = 1'b0;
    send("lui_x8", 32'h1234_5437, 32'h20C, 5'd0, 5'd0,
         mk(32'd0, 32'd0, 32'h1234_5000, 32'h1234_5437, 32'h20C, 5'd8, 1'b1, 1'b0), 0);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_sb", u_dut.u_sb.pend_q, 32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_imm", bus.imm_o, 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    chk("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
